// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client arbiter merging instruction and data ports onto one memory bus
module mem_arbiter #(
  parameter bit ROUND_ROBIN    = 1'b0,
  parameter int QUIET_CYCLES   = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic        i_resp,
  output logic [15:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [1:0]  d_byte_enable,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  output logic        d_resp,
  output logic [15:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_address,
  output logic [15:0] mem_wdata,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic        timeout_err
);
  localparam int CMAX = QUIET_CYCLES > TIMEOUT_CYCLES ? QUIET_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [1:0] {QUIET, IDLE, BUSY, GAP} state_t;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        last_data_q, last_data_d;
  logic        grant_data_q, grant_data_d;
  logic        err_q, err_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        i_req, d_req, pick_data, busy;
  assign i_req     = i_read;
  assign d_req     = d_read | d_write;
  assign pick_data = d_req & (~i_req | ~ROUND_ROBIN | ~last_data_q);
  assign busy      = state_q == BUSY;
  assign i_resp          = mem_resp & busy & ~grant_data_q;
  assign d_resp          = mem_resp & busy & grant_data_q;
  assign i_rdata         = mem_rdata;
  assign d_rdata         = mem_rdata;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = be_q;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;
  assign timeout_err     = err_q;
  // next-state: quiet countdown, grant capture, completion and timeout tracking
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_data_d  = last_data_q;
    grant_data_d = grant_data_q;
    err_d        = err_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unique case (state_q)
      QUIET: begin
        state_d = cnt_q == CW'(QUIET_CYCLES - 1) ? IDLE : QUIET;
        cnt_d   = cnt_q == CW'(QUIET_CYCLES - 1) ? '0 : cnt_q + CW'(1);
      end
      IDLE: if (i_req | d_req) begin
        state_d      = BUSY;
        cnt_d        = '0;
        grant_data_d = pick_data;
        last_data_d  = pick_data;
        mem_read_d   = ~pick_data | ~d_write;
        mem_write_d  = pick_data & d_write;
        be_d         = pick_data ? d_byte_enable : 2'b11;
        addr_d       = pick_data ? d_address : i_address;
        wdata_d      = pick_data ? d_wdata : 16'h0000;
      end
      BUSY: if (mem_resp) begin
        state_d     = GAP;
        cnt_d       = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end else begin
        cnt_d = cnt_q == CW'(TIMEOUT_CYCLES) ? cnt_q : cnt_q + CW'(1);
        err_d = err_q | (cnt_q == CW'(TIMEOUT_CYCLES - 1));
      end
      GAP: state_d = IDLE;
      default: state_d = QUIET;
    endcase
  end
  // state and registered memory-bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= QUIET;
      cnt_q        <= '0;
      last_data_q  <= 1'b0;
      grant_data_q <= 1'b0;
      err_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      be_q         <= 2'b00;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_data_q  <= last_data_d;
      grant_data_q <= grant_data_d;
      err_q        <= err_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed check of two arbiter instances (fixed priority and round robin)
module tb_mem_arbiter;
  localparam int QUIET = 32;
  localparam int TMO   = 64;
  typedef struct packed {
    logic        data;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_read [2], d_read [2], d_write [2], mem_resp [2];
  logic [15:0] i_address [2], d_address [2], d_wdata [2], mem_rdata [2];
  logic [1:0]  d_byte_enable [2];
  logic        i_resp [2], d_resp [2], mem_read [2], mem_write [2], timeout_err [2];
  logic [15:0] i_rdata [2], d_rdata [2], mem_address [2], mem_wdata [2];
  logic [1:0]  mem_byte_enable [2];
  int          vectors = 0;
  int          miscompares = 0;
  bit          armed = 0, rnd = 0, stall = 0, spur = 0, force_resp = 0;
  int          quiet_left [2], waited [2];
  bit          busy [2], gap [2], err [2], last_data [2], done_i [2], done_d [2];
  txn_t        cur [2];
  string       glog [2];
  logic [15:0] mem [2][256];

  always #5 clk = ~clk;

  mem_arbiter #(.ROUND_ROBIN(1'b0), .QUIET_CYCLES(QUIET), .TIMEOUT_CYCLES(TMO)) u0 (
    .clk(clk), .rst(rst),
    .i_read(i_read[0]), .i_address(i_address[0]), .i_resp(i_resp[0]), .i_rdata(i_rdata[0]),
    .d_read(d_read[0]), .d_write(d_write[0]), .d_byte_enable(d_byte_enable[0]),
    .d_address(d_address[0]), .d_wdata(d_wdata[0]), .d_resp(d_resp[0]), .d_rdata(d_rdata[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_byte_enable(mem_byte_enable[0]),
    .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]), .mem_resp(mem_resp[0]),
    .mem_rdata(mem_rdata[0]), .timeout_err(timeout_err[0]));

  mem_arbiter #(.ROUND_ROBIN(1'b1), .QUIET_CYCLES(QUIET), .TIMEOUT_CYCLES(TMO)) u1 (
    .clk(clk), .rst(rst),
    .i_read(i_read[1]), .i_address(i_address[1]), .i_resp(i_resp[1]), .i_rdata(i_rdata[1]),
    .d_read(d_read[1]), .d_write(d_write[1]), .d_byte_enable(d_byte_enable[1]),
    .d_address(d_address[1]), .d_wdata(d_wdata[1]), .d_resp(d_resp[1]), .d_rdata(d_rdata[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_byte_enable(mem_byte_enable[1]),
    .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]), .mem_resp(mem_resp[1]),
    .mem_rdata(mem_rdata[1]), .timeout_err(timeout_err[1]));

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // transaction-level reference: quiet countdown, one outstanding access, one idle gap after each
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      done_i[k] = 0;
      done_d[k] = 0;
      if (rst) begin
        quiet_left[k] = QUIET;
        busy[k] = 0;
        gap[k] = 0;
        err[k] = 0;
        last_data[k] = 0;
        waited[k] = 0;
        cur[k] = '0;
      end else if (quiet_left[k] > 0) quiet_left[k]--;
      else if (gap[k]) gap[k] = 0;
      else if (busy[k]) begin
        if (mem_resp[k]) begin
          if (cur[k].wr && cur[k].be[0]) mem[k][cur[k].addr[8:1]][7:0] = cur[k].wdata[7:0];
          if (cur[k].wr && cur[k].be[1]) mem[k][cur[k].addr[8:1]][15:8] = cur[k].wdata[15:8];
          done_i[k] = !cur[k].data;
          done_d[k] = cur[k].data;
          busy[k] = 0;
          gap[k] = 1;
        end else begin
          waited[k]++;
          if (waited[k] >= TMO) err[k] = 1;
        end
      end else if (i_read[k] || d_read[k] || d_write[k]) begin
        cur[k].data  = (d_read[k] || d_write[k]) && (!i_read[k] || k == 0 || !last_data[k]);
        cur[k].wr    = cur[k].data && d_write[k];
        cur[k].be    = cur[k].data ? d_byte_enable[k] : 2'b11;
        cur[k].addr  = cur[k].data ? d_address[k] : i_address[k];
        cur[k].wdata = cur[k].data ? d_wdata[k] : 16'h0000;
        last_data[k] = cur[k].data;
        busy[k] = 1;
        waited[k] = 0;
        glog[k] = {glog[k], cur[k].data ? "D" : "I"};
      end
    end
  end

  // every-cycle comparison of both instances against the reference
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk("mem_read", k, 16'(mem_read[k]), 16'(busy[k] && !cur[k].wr));
        chk("mem_write", k, 16'(mem_write[k]), 16'(busy[k] && cur[k].wr));
        chk("mem_be", k, 16'(mem_byte_enable[k]), 16'(cur[k].be));
        chk("mem_address", k, mem_address[k], cur[k].addr);
        chk("mem_wdata", k, mem_wdata[k], cur[k].wdata);
        chk("i_resp", k, 16'(i_resp[k]), 16'(busy[k] && mem_resp[k] && !cur[k].data));
        chk("d_resp", k, 16'(d_resp[k]), 16'(busy[k] && mem_resp[k] && cur[k].data));
        chk("i_rdata", k, i_rdata[k], mem_rdata[k]);
        chk("d_rdata", k, d_rdata[k], mem_rdata[k]);
        chk("timeout_err", k, 16'(timeout_err[k]), 16'(err[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (done_i[k]) i_read[k] = 0;
      if (done_d[k]) begin
        d_read[k] = 0;
        d_write[k] = 0;
      end
      if (rnd) begin
        if (!i_read[k]) i_read[k] = $urandom_range(0, 2) == 0;
        else if ($urandom_range(0, 15) == 0) i_read[k] = 0;
        if (!(d_read[k] || d_write[k])) begin
          if ($urandom_range(0, 2) == 0) begin
            d_read[k] = $urandom_range(0, 2) != 1;
            d_write[k] = !d_read[k] || $urandom_range(0, 3) == 0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          d_read[k] = 0;
          d_write[k] = 0;
        end
        i_address[k] = 16'($urandom);
        d_address[k] = 16'($urandom);
        d_wdata[k] = 16'($urandom);
        d_byte_enable[k] = 2'($urandom_range(1, 3));
      end
      mem_resp[k] = force_resp || (busy[k] ? (!stall && $urandom_range(0, 2) == 0)
                                           : (spur && $urandom_range(0, 7) == 0));
      mem_rdata[k] = (mem_resp[k] && busy[k] && !cur[k].wr) ? mem[k][cur[k].addr[8:1]] : 16'($urandom);
    end
  endtask

  task automatic settle();
    for (int n = 0; n < 300 && (busy[0] || gap[0] || busy[1] || gap[1]); n++) tick();
    chk("settle_idle", 0, 16'(busy[0] || busy[1]), 16'd0);
    tick();
    tick();
  endtask

  task automatic wait_all(input bit want_d, input logic [15:0] exp, input bit chk_rd);
    bit got [2];
    got[0] = 0;
    got[1] = 0;
    for (int n = 0; n < 300 && !(got[0] && got[1]); n++) begin
      tick();
      #2;
      for (int k = 0; k < 2; k++) begin
        if (!got[k] && busy[k] && mem_resp[k] && cur[k].data == want_d) begin
          got[k] = 1;
          chk("own_resp_lit", k, 16'(want_d ? d_resp[k] : i_resp[k]), 16'd1);
          chk("other_resp_lit", k, 16'(want_d ? i_resp[k] : d_resp[k]), 16'd0);
          if (chk_rd) chk("rdata_lit", k, want_d ? d_rdata[k] : i_rdata[k], exp);
        end
      end
    end
    for (int k = 0; k < 2; k++) chk("resp_seen", k, 16'(got[k]), 16'd1);
    settle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 0; d_read[k] = 0; d_write[k] = 0; mem_resp[k] = 0;
      i_address[k] = 0; d_address[k] = 0; d_wdata[k] = 0; d_byte_enable[k] = 0; mem_rdata[k] = 0;
      glog[k] = "";
      for (int i = 0; i < 256; i++) mem[k][i] = 16'h0000;
    end
    @(posedge clk);
    #1 armed = 1;
    @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_mem_read_lit", k, 16'(mem_read[k]), 16'd0);
      chk("rst_address_lit", k, mem_address[k], 16'h0000);
      chk("rst_timeout_lit", k, 16'(timeout_err[k]), 16'd0);
    end
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      mem[k][8] = 16'h1234;
      i_read[k] = 1;
      i_address[k] = 16'h0010;
    end
    repeat (10) tick();
    #2;
    for (int k = 0; k < 2; k++) chk("quiet_no_grant_lit", k, 16'(mem_read[k]), 16'd0);
    wait_all(0, 16'h1234, 1);
    for (int k = 0; k < 2; k++) glog[k] = "";
    for (int n = 0; n < 300 && (glog[0].len() < 3 || glog[1].len() < 3); n++) begin
      for (int k = 0; k < 2; k++) begin
        i_read[k] = glog[k].len() < 3;
        d_read[k] = glog[k].len() < 3;
        i_address[k] = 16'h0050;
        d_address[k] = 16'h0060;
        d_byte_enable[k] = 2'b11;
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 0;
      d_read[k] = 0;
    end
    chk("tie_order_rr0_lit", 0, 16'(glog[0] == "DDD"), 16'd1);
    chk("tie_order_rr1_lit", 1, 16'(glog[1] == "DID"), 16'd1);
    settle();
    for (int k = 0; k < 2; k++) begin
      mem[k][16] = 16'h0000;
      d_write[k] = 1;
      d_byte_enable[k] = 2'b01;
      d_address[k] = 16'h0020;
      d_wdata[k] = 16'hABCD;
    end
    stall = 1;
    repeat (3) tick();
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("wr_mem_write_lit", k, 16'(mem_write[k]), 16'd1);
      chk("wr_mem_read_lit", k, 16'(mem_read[k]), 16'd0);
      chk("wr_be_lit", k, 16'(mem_byte_enable[k]), 16'd1);
      chk("wr_wdata_lit", k, mem_wdata[k], 16'hABCD);
      d_address[k] = 16'h0040;
    end
    tick();
    #2;
    for (int k = 0; k < 2; k++) chk("addr_hold_lit", k, mem_address[k], 16'h0020);
    stall = 0;
    wait_all(1, 16'h0000, 0);
    for (int k = 0; k < 2; k++) begin
      d_read[k] = 1;
      d_byte_enable[k] = 2'b11;
      d_address[k] = 16'h0020;
    end
    wait_all(1, 16'h00CD, 1);
    for (int k = 0; k < 2; k++) begin
      d_read[k] = 1;
      d_address[k] = 16'h0100;
    end
    stall = 1;
    repeat (66) tick();
    #2;
    for (int k = 0; k < 2; k++) chk("timeout_set_lit", k, 16'(timeout_err[k]), 16'd1);
    stall = 0;
    wait_all(1, 16'h0000, 0);
    repeat (3) tick();
    #2;
    for (int k = 0; k < 2; k++) chk("timeout_sticky_lit", k, 16'(timeout_err[k]), 16'd1);
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1;
      i_address[k] = 16'h0030;
    end
    stall = 1;
    repeat (4) tick();
    #2;
    for (int k = 0; k < 2; k++) chk("busy_before_rst_lit", k, 16'(mem_read[k]), 16'd1);
    rst = 1;
    for (int k = 0; k < 2; k++) i_read[k] = 0;
    tick();
    rst = 0;
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy_read_lit", k, 16'(mem_read[k]), 16'd0);
      chk("rst_busy_addr_lit", k, mem_address[k], 16'h0000);
      chk("rst_clears_timeout_lit", k, 16'(timeout_err[k]), 16'd0);
    end
    repeat (9) tick();
    force_resp = 1;
    tick();
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("stale_i_resp_lit", k, 16'(i_resp[k]), 16'd0);
      chk("stale_d_resp_lit", k, 16'(d_resp[k]), 16'd0);
    end
    force_resp = 0;
    stall = 0;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 1;
      i_address[k] = 16'h0010;
    end
    repeat (8) tick();
    #2;
    for (int k = 0; k < 2; k++) chk("quiet_after_rst_lit", k, 16'(mem_read[k]), 16'd0);
    wait_all(0, 16'h1234, 1);
    rnd = 1;
    spur = 1;
    repeat (3000) tick();
    rnd = 0;
    spur = 0;
    for (int k = 0; k < 2; k++) begin
      i_read[k] = 0;
      d_read[k] = 0;
      d_write[k] = 0;
    end
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
